de0_hex_entry: RTL and testbench

- Operator input front-end for the DE0 board: debounces the three pushbuttons and assembles a 16-bit hex value, one nibble at a time, from SW[3:0].
- Produces the committed 16-bit value for the downstream 7-segment display driver and for the rest of the design.
- Also exposes the in-progress entry value, so the display can show digits as they are typed.

---
 rtl/de0_hex_entry.sv | 164 ++++++++++++++++
 tb/tb_de0_hex_entry.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/de0_hex_entry.sv
// DE0 operator front-end: debounced buttons build a 16-bit hex value from SW; DE0_HEX_ENTRY_AUTOCOMMIT_EN commits on the 4th digit.
// Latency: raw button edge to press pulse is 2 + DEBOUNCE_CYCLES clocks, action on the next edge; no backpressure.
module de0_hex_entry #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic [2:0]  BUTTON,
  input  logic [3:0]  SW,
  output logic [15:0] value,
  output logic        value_strobe,
  output logic [15:0] edit_value,
  output logic [2:0]  digit_count,
  output logic        full
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_FULL} state_t;

  logic [2:0]  btn_s1, btn_s2, press;
  logic [3:0]  sw_s1, sw_s2;
  state_t      state_q, state_d;
  logic        ev_clr, ev_com, ev_ent;
  logic [15:0] shifted;
  logic [15:0] value_d, edit_d;
  logic [2:0]  count_d;
  logic        strobe_d;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1 <= '1;
      btn_s2 <= '1;
      sw_s1  <= '1;
      sw_s2  <= '1;
    end else begin
      btn_s1 <= BUTTON;
      btn_s2 <= btn_s1;
      sw_s1  <= SW;
      sw_s2  <= sw_s1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_deb
    logic [CW-1:0] cnt;
    logic          deb;
    logic          prs;

    // Any agreeing cycle restarts the count, so only a run of DEBOUNCE_CYCLES disagreeing cycles is accepted.
    always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
        deb <= 1'b1;
        prs <= 1'b0;
      end else begin
        prs <= 1'b0;
        if (btn_s2[i] == deb) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          cnt <= '0;
          deb <= btn_s2[i];
          prs <= ~btn_s2[i];
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end

    assign press[i] = prs;
  end

  assign ev_clr  = press[2];
  assign ev_com  = press[1] & ~press[2];
  assign ev_ent  = press[0] & ~press[1] & ~press[2];
  assign shifted = {edit_value[11:0], sw_s2};

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (ev_ent) state_d = S_ENTRY;
      S_ENTRY: begin
        if (ev_clr || ev_com) begin
          state_d = S_IDLE;
        end else if (ev_ent && digit_count == 3'd3) begin
`ifdef DE0_HEX_ENTRY_AUTOCOMMIT_EN
          state_d = S_IDLE;
`else
          state_d = S_FULL;
`endif
        end
      end
      S_FULL: if (ev_clr || ev_com) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    value_d  = value;
    edit_d   = edit_value;
    count_d  = digit_count;
    strobe_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ev_ent) begin
          edit_d  = shifted;
          count_d = 3'd1;
        end
      end
      S_ENTRY, S_FULL: begin
        if (ev_clr) begin
          edit_d  = '0;
          count_d = '0;
        end else if (ev_com) begin
          value_d  = edit_value;
          strobe_d = 1'b1;
          edit_d   = '0;
          count_d  = '0;
        end else if (ev_ent && state_q == S_ENTRY) begin
`ifdef DE0_HEX_ENTRY_AUTOCOMMIT_EN
          if (digit_count == 3'd3) begin
            value_d  = shifted;
            strobe_d = 1'b1;
            edit_d   = '0;
            count_d  = '0;
          end else begin
            edit_d  = shifted;
            count_d = digit_count + 3'd1;
          end
`else
          edit_d  = shifted;
          count_d = digit_count + 3'd1;
`endif
        end
      end
      default: begin
        edit_d  = '0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      value        <= '0;
      value_strobe <= 1'b0;
      edit_value   <= '0;
      digit_count  <= '0;
      full         <= 1'b0;
    end else begin
      value        <= value_d;
      value_strobe <= strobe_d;
      edit_value   <= edit_d;
      digit_count  <= count_d;
      full         <= (state_d == S_FULL);
    end
  end

endmodule

// File: tb/tb_de0_hex_entry.sv
// Randomized self-checking bench for de0_hex_entry against a digit-queue model (DEBOUNCE_CYCLES=4).
module tb_de0_hex_entry;

  logic        clk_50 = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  BUTTON = 3'b111;
  logic [3:0]  SW = 4'h0;
  logic [15:0] value, edit_value;
  logic        value_strobe, full;
  logic [2:0]  digit_count;

  int n_tests = 0;
  int n_fail = 0;
  int strobe_cnt = 0;
  int m_strobes = 0;

  logic [3:0]  digits[$];
  logic [15:0] m_value = 16'h0;
  logic [35:0] dut_state, exp_state;

  de0_hex_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk_50(clk_50), .reset_n(reset_n), .BUTTON(BUTTON), .SW(SW),
    .value(value), .value_strobe(value_strobe), .edit_value(edit_value),
    .digit_count(digit_count), .full(full)
  );

  always #10 clk_50 = ~clk_50;

  always @(negedge clk_50) if (value_strobe === 1'b1) strobe_cnt++;

  assign dut_state = {value, edit_value, digit_count, full};

  function automatic logic [15:0] m_edit();
    int r = 0;
    foreach (digits[i]) r = r * 16 + int'(digits[i]);
    return 16'(r);
  endfunction

  function automatic logic [35:0] m_state();
    return {m_value, m_edit(), 3'(digits.size()), digits.size() == 4};
  endfunction

  // Model: clear beats commit beats enter; commit of nothing is ignored; a 5th digit is dropped.
  task automatic model_press(input logic [2:0] mask, input logic [3:0] sw);
    if (mask[2]) begin
      digits.delete();
    end else if (mask[1]) begin
      if (digits.size() > 0) begin
        m_value = m_edit();
        m_strobes++;
        digits.delete();
      end
    end else if (mask[0]) begin
      if (digits.size() < 4) begin
        digits.push_back(sw);
`ifdef DE0_HEX_ENTRY_AUTOCOMMIT_EN
        if (digits.size() == 4) begin
          m_value = m_edit();
          m_strobes++;
          digits.delete();
        end
`endif
      end
    end
  endtask

  task automatic drive_press(input logic [2:0] mask, input logic [3:0] sw, input int hold);
    @(posedge clk_50); #1;
    SW = sw;
    BUTTON = ~mask;
    repeat (hold) @(posedge clk_50);
    #1 BUTTON = 3'b111;
    repeat (12) @(posedge clk_50);
    @(negedge clk_50);
  endtask

  task automatic press(input logic [2:0] mask, input logic [3:0] sw);
    drive_press(mask, sw, 6);
    model_press(mask, sw);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk_50);
    n_tests++;
    if (dut_state !== 36'h0 || value_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got state=%h strobe=%b, want 0/0", dut_state, value_strobe);
    end
    #3 reset_n = 1'b1;
    repeat (20) @(negedge clk_50);
    exp_state = m_state();
    n_tests++;
    if (dut_state !== exp_state) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h want %h", dut_state, exp_state);
    end
    n_tests++;
    if (strobe_cnt !== 0) begin
      n_fail++;
      $display("FAIL idle_strobe: got %0d strobes want 0", strobe_cnt);
    end
  endtask

  task automatic test_entry_commit();
    int s0;
    s0 = strobe_cnt;
    for (int d = 1; d <= 4; d++) press(3'b001, 4'(d));
    exp_state = m_state();
    n_tests++;
    if (dut_state !== exp_state) begin
      n_fail++;
      $display("FAIL entry_1234: got val/edit/cnt/full=%h/%h/%0d/%b want %h/%h/%0d/%b",
               value, edit_value, digit_count, full,
               exp_state[35:20], exp_state[19:4], exp_state[3:1], exp_state[0]);
    end
    press(3'b010, 4'h0);
    exp_state = m_state();
    n_tests++;
    if (dut_state !== exp_state || value !== 16'h1234) begin
      n_fail++;
      $display("FAIL commit_1234: got %h want %h (value %h want 1234)", dut_state, exp_state, value);
    end
    n_tests++;
    if (strobe_cnt - s0 !== 1) begin
      n_fail++;
      $display("FAIL commit_strobe: got %0d strobe cycles want 1", strobe_cnt - s0);
    end
  endtask

  task automatic test_glitch();
    int c0;
    for (int g = 1; g <= 3; g++) begin
      drive_press(3'b001, 4'h9, g);
      exp_state = m_state();
      n_tests++;
      if (dut_state !== exp_state) begin
        n_fail++;
        $display("FAIL glitch_%0d: got %h want %h", g, dut_state, exp_state);
      end
    end
    // 4-cycle pulse: press pulse after edge 6, digit lands at edge 7 counted from the raw edge.
    c0 = digits.size();
    SW = 4'h7;
    @(posedge clk_50); #1 BUTTON = 3'b110;
    repeat (4) @(posedge clk_50);
    #1 BUTTON = 3'b111;
    repeat (2) @(posedge clk_50);
    @(negedge clk_50);
    n_tests++;
    if (digit_count !== 3'(c0)) begin
      n_fail++;
      $display("FAIL latency_early: got count %0d want %0d", digit_count, c0);
    end
    @(negedge clk_50);
    n_tests++;
    if (digit_count !== 3'(c0 + 1)) begin
      n_fail++;
      $display("FAIL latency_on_time: got count %0d want %0d", digit_count, c0 + 1);
    end
    model_press(3'b001, 4'h7);
    repeat (12) @(negedge clk_50);
    exp_state = m_state();
    n_tests++;
    if (dut_state !== exp_state) begin
      n_fail++;
      $display("FAIL pulse4_entry: got %h want %h", dut_state, exp_state);
    end
  endtask

  task automatic test_clear();
    int s0;
    press(3'b100, 4'h0);
    press(3'b001, 4'hA);
    press(3'b001, 4'h5);
    s0 = strobe_cnt;
    press(3'b100, 4'h0);
    exp_state = m_state();
    n_tests++;
    if (dut_state !== exp_state || edit_value !== 16'h0) begin
      n_fail++;
      $display("FAIL clear: got %h want %h", dut_state, exp_state);
    end
    press(3'b010, 4'h0);
    n_tests++;
    if (strobe_cnt !== s0 || dut_state !== m_state()) begin
      n_fail++;
      $display("FAIL commit_idle: got %0d strobes state %h want %0d / %h", strobe_cnt - s0, dut_state, 0, m_state());
    end
    press(3'b001, 4'hA);
    press(3'b001, 4'h5);
    press(3'b010, 4'h0);
    n_tests++;
    if (value !== 16'h00A5 || dut_state !== m_state()) begin
      n_fail++;
      $display("FAIL partial_commit: got value %h want 00a5 (state %h want %h)", value, dut_state, m_state());
    end
  endtask

  task automatic test_full();
    int s0;
    for (int d = 1; d <= 4; d++) press(3'b001, 4'(d));
    press(3'b001, 4'hF);
    exp_state = m_state();
    n_tests++;
    if (dut_state !== exp_state) begin
      n_fail++;
      $display("FAIL fifth_digit: got %h want %h", dut_state, exp_state);
    end
    s0 = strobe_cnt;
    press(3'b110, 4'h0);
    exp_state = m_state();
    n_tests++;
    if (dut_state !== exp_state || strobe_cnt !== s0) begin
      n_fail++;
      $display("FAIL clear_beats_commit: got %h strobes %0d want %h strobes 0", dut_state, strobe_cnt - s0, exp_state);
    end
  endtask

  task automatic test_random();
    int r;
    logic [2:0] mask;
    logic [3:0] sw;
    for (int it = 0; it < 30; it++) begin
      r  = $urandom_range(0, 9);
      sw = 4'($urandom_range(0, 15));
      if (r < 5)      mask = 3'b001;
      else if (r < 7) mask = 3'b010;
      else if (r < 8) mask = 3'b100;
      else            mask = 3'($urandom_range(1, 7));
      press(mask, sw);
      exp_state = m_state();
      n_tests++;
      if (dut_state !== exp_state) begin
        n_fail++;
        $display("FAIL random_%0d mask=%b sw=%h: got %h want %h", it, mask, sw, dut_state, exp_state);
      end
    end
    n_tests++;
    if (strobe_cnt !== m_strobes) begin
      n_fail++;
      $display("FAIL strobe_total: got %0d want %0d", strobe_cnt, m_strobes);
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    press(3'b100, 4'h0);
    press(3'b001, 4'h3);
    @(posedge clk_50); #1 BUTTON = 3'b110;
    repeat (3) @(posedge clk_50);
    #3 reset_n = 1'b0;
    #1;
    n_tests++;
    if (dut_state !== 36'h0 || value_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got state %h strobe %b want 0/0", dut_state, value_strobe);
    end
    digits.delete();
    m_value = 16'h0;
    BUTTON = 3'b111;
    s0 = strobe_cnt;
    repeat (2) @(posedge clk_50);
    #5 reset_n = 1'b1;
    repeat (20) @(negedge clk_50);
    n_tests++;
    if (dut_state !== m_state() || strobe_cnt !== s0) begin
      n_fail++;
      $display("FAIL post_reset: got %h strobes %0d want %h strobes 0", dut_state, strobe_cnt - s0, m_state());
    end
    m_strobes = strobe_cnt;
    test_entry_commit();
  endtask

  initial begin
    test_reset();
    test_entry_commit();
    test_glitch();
    test_clear();
    test_full();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
